// File: rtl/bcd_counter_ud.sv
// N-digit up/down BCD counter with clear, load, optional saturation and zero flag.
// Define BCD_LOAD_CHECK_EN to reject loads containing non-BCD digits (flagged on Err).

module bcd_digit (
    input  logic [3:0] d,
    input  logic       up,
    input  logic       step,
    output logic [3:0] nxt,
    output logic       is9,
    output logic       ge9,
    output logic       is0
);
    assign is9 = (d == 4'd9);
    assign ge9 = (d >= 4'd9);
    assign is0 = (d == 4'd0);

    // Illegal codes above 9 roll to 0 going up and simply decrement going down.
    always_comb begin
        nxt = d;
        if (step) begin
            if (up) nxt = ge9 ? 4'd0 : d + 4'd1;
            else    nxt = is0 ? 4'd9 : d - 4'd1;
        end
    end
endmodule

module bcd_counter_ud #(
    parameter int DIGITS = 3,
    parameter bit SAT    = 1'b0
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Cin,
    input  logic                Up,
    input  logic                Clr,
    input  logic                Load,
    input  logic [4*DIGITS-1:0] D,
    output logic [4*DIGITS-1:0] q,
    output logic                Cout,
    output logic                Zero,
    output logic                Err
);
    logic [DIGITS-1:0][3:0] cnt_q, cnt_nxt, step_val, dd;
    logic [DIGITS-1:0]      is9, ge9, is0, en_up, en_dn, step;
    logic                   all9, all0, term, load_ok;

    assign dd = D;
    assign q  = cnt_q;

    // Each digit's enable is a flat AND over all lower digits so the chain stays shallow.
    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        if (k == 0) begin : g_lsd
            assign en_up[k] = 1'b1;
            assign en_dn[k] = 1'b1;
        end else begin : g_upper
            assign en_up[k] = &ge9[k-1:0];
            assign en_dn[k] = &is0[k-1:0];
        end
        assign step[k] = Up ? en_up[k] : en_dn[k];

        bcd_digit u_dig (
            .d    (cnt_q[k]),
            .up   (Up),
            .step (step[k]),
            .nxt  (step_val[k]),
            .is9  (is9[k]),
            .ge9  (ge9[k]),
            .is0  (is0[k])
        );
    end

    assign all9 = &is9;
    assign all0 = &is0;
    assign term = Up ? all9 : all0;
    assign Cout = Cin & term;

`ifdef BCD_LOAD_CHECK_EN
    logic [DIGITS-1:0] bad_dig;
    logic              err_nxt;

    for (genvar k = 0; k < DIGITS; k++) begin : g_chk
        assign bad_dig[k] = (dd[k] > 4'd9);
    end
    assign load_ok = ~|bad_dig;
    assign err_nxt = Load & ~Clr & ~load_ok;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) Err <= 1'b0;
        else     Err <= err_nxt;
    end
`else
    assign load_ok = 1'b1;
    assign Err     = 1'b0;
`endif

    always_comb begin
        cnt_nxt = cnt_q;
        if (Clr)                         cnt_nxt = '0;
        else if (Load)                   cnt_nxt = load_ok ? dd : cnt_q;
        else if (Cin && !(SAT && term))  cnt_nxt = step_val;
    end

    // Zero is registered from the next value so it lines up with q.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
            Zero  <= 1'b1;
        end else begin
            cnt_q <= cnt_nxt;
            Zero  <= (cnt_nxt == '0);
        end
    end
endmodule

// File: tb/tb_bcd_counter_ud.sv
// Scoreboard bench for bcd_counter_ud: wrapping (dut 0) and saturating (dut 1) instances share stimulus.
module tb_bcd_counter_ud;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1, Cin = 1'b0, Up = 1'b0, Clr = 1'b0, Load = 1'b0;
    logic [11:0] D = '0;
    logic [11:0] q0, q1;
    logic        cout0, cout1, zero0, zero1, err0, err1;

    typedef struct {
        int          dut;
        logic [11:0] q;
        logic        z;
        logic        c;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 Clk = ~Clk;

    bcd_counter_ud #(.DIGITS(3), .SAT(1'b0)) u_wrap (
        .Clk(Clk), .Rst(Rst), .Cin(Cin), .Up(Up), .Clr(Clr), .Load(Load), .D(D),
        .q(q0), .Cout(cout0), .Zero(zero0), .Err(err0)
    );

    bcd_counter_ud #(.DIGITS(3), .SAT(1'b1)) u_sat (
        .Clk(Clk), .Rst(Rst), .Cin(Cin), .Up(Up), .Clr(Clr), .Load(Load), .D(D),
        .q(q1), .Cout(cout1), .Zero(zero1), .Err(err1)
    );

`ifdef BCD_LOAD_CHECK_EN
    localparam logic [11:0] AFTER_BAD = 12'h042;
    localparam logic        BAD_ERR   = 1'b1;
`else
    localparam logic [11:0] AFTER_BAD = 12'h1A3;
    localparam logic        BAD_ERR   = 1'b0;
`endif

    // Apply one cycle of inputs; expectations describe what is seen before that cycle's edge.
    task automatic vec(input int dut, input logic rst, input logic clr, input logic load,
                       input logic cin, input logic up, input logic [11:0] d,
                       input logic [11:0] eq, input logic ez, input logic ec, input logic ee);
        exp_t x;
        @(posedge Clk);
        #1;
        Rst = rst; Clr = clr; Load = load; Cin = cin; Up = up; D = d;
        x.dut = dut; x.q = eq; x.z = ez; x.c = ec; x.e = ee;
        exp_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t        x;
        logic [11:0] aq;
        logic        az, ac, ae;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                x  = exp_q.pop_front();
                aq = x.dut ? q1 : q0;
                az = x.dut ? zero1 : zero0;
                ac = x.dut ? cout1 : cout0;
                ae = x.dut ? err1 : err0;
                vectors++;
                if (aq !== x.q || az !== x.z || ac !== x.c || ae !== x.e) begin
                    miscompares++;
                    $display("FAIL vec%0d dut%0d: got q=%h zero=%b cout=%b err=%b, want q=%h zero=%b cout=%b err=%b",
                             vectors, x.dut, aq, az, ac, ae, x.q, x.z, x.c, x.e);
                end
            end
        end
    end

    initial begin : driver
        //   dut rst clr ld cin up  D        q        z     c     e
        vec(0, 1, 0, 0, 0, 0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0); // reset state
        vec(0, 0, 0, 1, 0, 0, 12'h998, 12'h000, 1'b1, 1'b0, 1'b0);
        vec(0, 0, 0, 0, 1, 1, 12'h000, 12'h998, 1'b0, 1'b0, 1'b0);
        vec(0, 0, 0, 0, 1, 1, 12'h000, 12'h999, 1'b0, 1'b1, 1'b0); // wrap up
        vec(0, 0, 0, 0, 1, 1, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0);
        vec(0, 0, 0, 0, 1, 0, 12'h000, 12'h001, 1'b0, 1'b0, 1'b0);
        vec(0, 0, 0, 0, 1, 0, 12'h000, 12'h000, 1'b1, 1'b1, 1'b0); // wrap down
        vec(0, 0, 0, 0, 1, 0, 12'h000, 12'h999, 1'b0, 1'b0, 1'b0);
        vec(0, 0, 0, 0, 0, 0, 12'h000, 12'h998, 1'b0, 1'b0, 1'b0);
        vec(0, 0, 0, 1, 0, 0, 12'h997, 12'h998, 1'b0, 1'b0, 1'b0);
        vec(1, 0, 0, 0, 1, 1, 12'h000, 12'h997, 1'b0, 1'b0, 1'b0); // saturate up
        vec(1, 0, 0, 0, 1, 1, 12'h000, 12'h998, 1'b0, 1'b0, 1'b0);
        vec(1, 0, 0, 0, 1, 1, 12'h000, 12'h999, 1'b0, 1'b1, 1'b0);
        vec(1, 0, 0, 0, 1, 1, 12'h000, 12'h999, 1'b0, 1'b1, 1'b0);
        vec(1, 0, 0, 0, 1, 1, 12'h000, 12'h999, 1'b0, 1'b1, 1'b0);
        vec(1, 0, 0, 0, 0, 1, 12'h000, 12'h999, 1'b0, 1'b0, 1'b0);
        vec(1, 0, 0, 1, 0, 0, 12'h002, 12'h999, 1'b0, 1'b0, 1'b0);
        vec(1, 0, 0, 0, 1, 0, 12'h000, 12'h002, 1'b0, 1'b0, 1'b0); // saturate down
        vec(1, 0, 0, 0, 1, 0, 12'h000, 12'h001, 1'b0, 1'b0, 1'b0);
        vec(1, 0, 0, 0, 1, 0, 12'h000, 12'h000, 1'b1, 1'b1, 1'b0);
        vec(1, 0, 0, 0, 1, 0, 12'h000, 12'h000, 1'b1, 1'b1, 1'b0);
        vec(1, 0, 0, 0, 1, 1, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0); // reversal
        vec(1, 0, 0, 0, 0, 0, 12'h000, 12'h001, 1'b0, 1'b0, 1'b0);
        vec(0, 0, 1, 1, 1, 1, 12'h123, 12'h999, 1'b0, 1'b1, 1'b0); // clr beats load/cin
        vec(0, 0, 0, 1, 0, 0, 12'h123, 12'h000, 1'b1, 1'b0, 1'b0);
        vec(0, 0, 0, 1, 0, 0, 12'h456, 12'h123, 1'b0, 1'b0, 1'b0);
        vec(0, 0, 0, 0, 1, 1, 12'h000, 12'h456, 1'b0, 1'b0, 1'b0);
        vec(0, 1, 0, 0, 1, 1, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0); // async reset mid-cycle
        vec(0, 0, 0, 0, 1, 1, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0);
        vec(0, 0, 0, 0, 0, 0, 12'h000, 12'h001, 1'b0, 1'b0, 1'b0);
        vec(0, 0, 0, 1, 0, 0, 12'h042, 12'h001, 1'b0, 1'b0, 1'b0);
        vec(0, 0, 0, 1, 0, 0, 12'h1A3, 12'h042, 1'b0, 1'b0, 1'b0); // illegal digit load
        vec(0, 0, 0, 0, 0, 0, 12'h000, AFTER_BAD, 1'b0, 1'b0, BAD_ERR);
        vec(0, 0, 0, 1, 0, 0, 12'h193, AFTER_BAD, 1'b0, 1'b0, 1'b0);
        vec(0, 0, 0, 0, 0, 0, 12'h000, 12'h193, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
        #1;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bcd_counter_ud.md
# bcd_counter_ud

Parametrised N-digit BCD counter: the next generation of the fixed three-digit ripple counter. It adds up/down counting, synchronous clear, parallel load, optional saturation and a zero flag. Count enable comes from an upstream carry or tick (`Cin`), and `Cout` cascades into further counter stages. It sits in the display and timebase paths, between the tick generators and the seven-segment or readout logic.

## Interface
Parameters:
- `DIGITS`, 3: number of BCD digits, range 1–8. Digit 0 is the least significant, in `q[3:0]`.
- `SAT`, 0: terminal behaviour. 0 wraps around; 1 saturates at the terminal value.

Ports:
- `Clk` input 1: counter clock; all state changes on the rising edge.
- `Rst` input 1: asynchronous, active-high reset.
- `Cin` input 1: count enable / carry-in; one step per cycle while high.
- `Up` input 1: direction; 1 counts up, 0 counts down. Sampled with `Cin`.
- `Clr` input 1: synchronous clear to 0.
- `Load` input 1: synchronous parallel load of `D`.
- `D` input 4*DIGITS: BCD load value.
- `q` output 4*DIGITS: registered count value.
- `Cout` output 1: carry-out (counting up) or borrow-out (counting down); combinational.
- `Zero` output 1: registered; high when `q` is all zeros.
- `Err` output 1: registered load-error pulse. Held at 0 when `BCD_LOAD_CHECK_EN` is undefined.

## Operation
- Per-cycle priority: `Rst` > `Clr` > `Load` > `Cin`. A lower-priority request in the same cycle is ignored, and `Up` has no effect unless a count occurs.
- **Count up** (`Cin`=1, `Up`=1):
  - Digit k increments when every lower digit is 9.
  - A digit at 9 rolls to 0; a digit above 9 also rolls to 0 and counts as 9 for carry.
- **Count down** (`Cin`=1, `Up`=0):
  - Digit k decrements when every lower digit is 0.
  - A digit at 0 goes to 9; a nonzero digit goes to digit−1, including illegal values (0xF→0xE).
- **Terminal value**: all 9s when counting up, all 0s when counting down.
  - `SAT`=0: the count wraps (99…9→00…0 up, 00…0→99…9 down).
  - `SAT`=1: `q` holds at the terminal value while `Cin` remains high.
- **Cout** = `Cin` & (`Up` ? q==all 9s : q==all 0s).
  - Asserted in the same cycle the terminal count is reached, independent of `SAT`.
  - A cascaded stage driven by `Cout` steps on the same edge as this stage wraps.
- **Zero**: registered, equals (next q == 0). It tracks `q` with no extra lag.
- **Clr**: `q`←0 and `Zero`←1.
- **Load**: `q`←`D`. `Zero` updates accordingly.
- State is the `q` register plus the `Zero` and `Err` flops only; there is no FSM beyond the count.

## Timing
- Reset values: `q`=0, `Zero`=1, `Err`=0. `Cout`=0 whenever `Cin`=0 (so `Cout`=0 while `Rst` is held with `Cin` low).
- `Rst` asserted mid-count clears immediately, asynchronously. Counting resumes on the first rising edge after `Rst` deasserts with `Cin`=1.
- Latency:
  - `Load`/`Clr`/count take effect on `q` one edge after sampling.
  - `Cout` is combinational from `Cin`, `Up` and `q`; there is zero-cycle ripple through all digits.
- Throughput: one step per cycle. Back-to-back `Cin` is fully supported.
- Direction reversal on consecutive cycles is allowed; each cycle uses that cycle's `Up`.
- Critical path: carry chain over `DIGITS` digits. Implement lookahead terminal-detect per digit, not a serial ripple, for `DIGITS` > 4.

## Configuration
- Macro `BCD_LOAD_CHECK_EN` defined:
  - A `Load` with any digit of `D` > 9 is rejected: `q` is unchanged.
  - `Err` pulses high for exactly one cycle following the rejected load.
  - Valid loads leave `Err`=0.
- Macro undefined:
  - `D` is loaded unchecked; illegal digits follow the count rules above.
  - `Err` is constant 0 and no checking logic is synthesised.

## Test plan
- Wrap up, `DIGITS`=3, `SAT`=0: load 998, `Cin`=1, `Up`=1 for 3 cycles → `q` 999, 000, 001. `Cout`=1 only in the cycle `q`=999.
- Wrap down: `q`=001, `Up`=0, `Cin`=1 for 3 cycles → `q` 000, 999, 998. `Cout`=1 only while `q`=000. `Zero`=1 only while `q`=000.
- Saturation, `SAT`=1:
  - Load 997, count up 5 cycles → 998, 999, 999, 999, 999. `Cout`=1 on every cycle `q`=999 with `Cin`=1.
  - Symmetric check down at 000.
- Priority: `Clr`=1, `Load`=1 (`D`=0x123) and `Cin`=1 in the same cycle → `q`=000, `Zero`=1. Next cycle `Load` only → `q`=123.
- Async reset: assert `Rst` mid-edge-interval while counting at 456 → `q`=000 before the next edge, `Zero`=1, `Err`=0. Release → counts from 000.
- `BCD_LOAD_CHECK_EN` defined: load `D`=0x1A3 with `q`=042 → `q` stays 042 and `Err`=1 for one cycle. Load 0x193 → `q`=193, `Err`=0.
